// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller. Tracks the destination registers of the
//   instructions in EX, MEM and WB with a small shadow scoreboard. It
//   detects load-use hazards, handles branch/CSR redirects and data-memory
//   wait states, and produces registered forwarding selects for the
//   instruction entering EX.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   id_*                description of the instruction currently in ID
//   redirect            PC redirect taken from the EX/MEM register
//   mem_busy            data memory not ready, freezes the whole pipe
//   pc_keep, ifid_keep, idex_keep, ex_keep   hold controls (combinational)
//   idex_nop, ex_nop, ifid_flush             squash controls (combinational)
//   fwd_ex/mem/hz/load_pyc   forwarding selects, bit1 = rs1, bit0 = rs2
//   stall_cnt           saturating count of cycles with pc_keep = 1
//   state               FSM state: 0 RUN, 1 LDSTALL, 2 MEMWAIT
//
// Handshake: there is no valid/ready pair. The pipe advances on every edge
// where mem_busy = 0; mem_busy = 1 freezes PC, IF/ID, ID/EX, EX and the
// scoreboard for that edge.
// ---------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_wreg,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        redirect,
  input  logic        mem_busy,
  output logic        pc_keep,
  output logic        ifid_keep,
  output logic        idex_keep,
  output logic        idex_nop,
  output logic        ifid_flush,
  output logic        ex_keep,
  output logic        ex_nop,
  output logic [1:0]  fwd_ex_pyc,
  output logic [1:0]  fwd_mem_pyc,
  output logic [1:0]  fwd_hz_pyc,
  output logic [1:0]  fwd_load_pyc,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state
);

  typedef struct packed {
    logic       valid;
    logic [4:0] wreg;
    logic       regwrite;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_MEMWAIT = 2'd2,
    S_BAD     = 2'd3
  } state_t;

  sb_entry_t  r_e, r_m, r_w;
  state_t     r_state;
  logic [1:0] r_fwd_ex, r_fwd_mem, r_fwd_hz, r_fwd_load;
  logic [15:0] r_stall_cnt;

  function automatic logic f_match(input sb_entry_t ent, input logic [4:0] src,
                                   input logic use_bit);
    return ent.valid && ent.regwrite && (ent.wreg != 5'd0) &&
           (ent.wreg == src) && use_bit;
  endfunction

  // Select one forwarding source for one operand: {ex, mem, hz, load}.
  // A loading producer in E never reaches here with a valid consumer, since
  // that case stalls instead.
  function automatic logic [3:0] f_sel(input logic e_hit, input logic e_load,
                                       input logic m_hit, input logic m_load,
                                       input logic w_hit);
    if (e_hit && !e_load)     return 4'b1000;
    else if (m_hit && m_load) return 4'b0001;
    else if (m_hit)           return 4'b0100;
    else if (w_hit)           return 4'b0010;
    else                      return 4'b0000;
  endfunction

  logic w_e1, w_e2, w_m1, w_m2, w_w1, w_w2;
  logic w_load_use, w_act_redir, w_act_ldu, w_act_adv;
  logic [3:0] w_sel1, w_sel2;
  sb_entry_t w_id_entry;

  assign w_e1 = f_match(r_e, id_rs1, id_use_rs1);
  assign w_e2 = f_match(r_e, id_rs2, id_use_rs2);
  assign w_m1 = f_match(r_m, id_rs1, id_use_rs1);
  assign w_m2 = f_match(r_m, id_rs2, id_use_rs2);
  assign w_w1 = f_match(r_w, id_rs1, id_use_rs1);
  assign w_w2 = f_match(r_w, id_rs2, id_use_rs2);

  // LDSTALL always leaves a bubble in E, so a second back-to-back load stall
  // cannot occur; the state term only makes the one-cycle length explicit.
  assign w_load_use = id_valid && r_e.is_load && (w_e1 || w_e2) &&
                      (r_state != S_LDSTALL);

  // Priority: mem_busy > redirect > load-use > advance.
  assign w_act_redir = !mem_busy && redirect;
  assign w_act_ldu   = !mem_busy && !redirect && w_load_use;
  assign w_act_adv   = !mem_busy && !redirect && !w_load_use;

  assign w_sel1 = id_valid ? f_sel(w_e1, r_e.is_load, w_m1, r_m.is_load, w_w1) : 4'b0000;
  assign w_sel2 = id_valid ? f_sel(w_e2, r_e.is_load, w_m2, r_m.is_load, w_w2) : 4'b0000;

  assign w_id_entry = id_valid ? '{valid: 1'b1, wreg: id_wreg,
                                   regwrite: id_regwrite, is_load: id_is_load}
                               : '0;

  // Controls are forced low while reset is asserted.
  assign pc_keep    = rst && (mem_busy || w_act_ldu);
  assign ifid_keep  = rst && (mem_busy || w_act_ldu);
  assign idex_keep  = rst && mem_busy;
  assign ex_keep    = rst && mem_busy;
  assign idex_nop   = rst && (w_act_redir || w_act_ldu);
  assign ifid_flush = rst && w_act_redir;
  assign ex_nop     = rst && w_act_redir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e         <= '0;
      r_m         <= '0;
      r_w         <= '0;
      r_state     <= S_RUN;
      r_fwd_ex    <= '0;
      r_fwd_mem   <= '0;
      r_fwd_hz    <= '0;
      r_fwd_load  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (pc_keep && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;

      case (r_state)
        S_LDSTALL: r_state <= mem_busy ? S_MEMWAIT : S_RUN;
        S_RUN, S_MEMWAIT:
          r_state <= mem_busy ? S_MEMWAIT : (w_act_ldu ? S_LDSTALL : S_RUN);
        default:   r_state <= S_RUN;
      endcase

      // Memory wait freezes scoreboard and forwarding selects.
      if (!mem_busy) begin
        r_w <= r_m;
        // On redirect the instruction in EX is squashed, so it must not
        // forward from MEM next cycle.
        r_m <= w_act_redir ? '0 : r_e;
        r_e <= w_act_adv ? w_id_entry : '0;
        if (w_act_adv) begin
          r_fwd_ex   <= {w_sel1[3], w_sel2[3]};
          r_fwd_mem  <= {w_sel1[2], w_sel2[2]};
          r_fwd_hz   <= {w_sel1[1], w_sel2[1]};
          r_fwd_load <= {w_sel1[0], w_sel2[0]};
        end else begin
          r_fwd_ex   <= '0;
          r_fwd_mem  <= '0;
          r_fwd_hz   <= '0;
          r_fwd_load <= '0;
        end
      end
    end
  end

  assign fwd_ex_pyc   = r_fwd_ex;
  assign fwd_mem_pyc  = r_fwd_mem;
  assign fwd_hz_pyc   = r_fwd_hz;
  assign fwd_load_pyc = r_fwd_load;
  assign stall_cnt    = r_stall_cnt;
  assign state        = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed scenarios followed by random traffic for hazard_ctrl. A model
//   of the pipeline (three instruction slots E, M, W) predicts every cycle's
//   controls, forwarding selects, stall count and state.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int OBS_W = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_wreg = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        id_regwrite = 1'b0, id_is_load = 1'b0;
  logic        redirect = 1'b0, mem_busy = 1'b0;
  logic        pc_keep, ifid_keep, idex_keep, idex_nop, ifid_flush, ex_keep, ex_nop;
  logic [1:0]  fwd_ex_pyc, fwd_mem_pyc, fwd_hz_pyc, fwd_load_pyc;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .redirect(redirect), .mem_busy(mem_busy),
    .pc_keep(pc_keep), .ifid_keep(ifid_keep), .idex_keep(idex_keep),
    .idex_nop(idex_nop), .ifid_flush(ifid_flush), .ex_keep(ex_keep), .ex_nop(ex_nop),
    .fwd_ex_pyc(fwd_ex_pyc), .fwd_mem_pyc(fwd_mem_pyc),
    .fwd_hz_pyc(fwd_hz_pyc), .fwd_load_pyc(fwd_load_pyc),
    .stall_cnt(stall_cnt), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  ins_t        pipe [3];            // 0 = in EX, 1 = in MEM, 2 = in WB
  logic [1:0]  m_fex, m_fmem, m_fhz, m_fload;
  logic [15:0] m_cnt;
  logic [1:0]  m_state;

  logic [OBS_W-1:0] exp_q[$];

  function automatic bit hit(input ins_t s, input logic [4:0] src, input logic u);
    return s.v && s.wr && (s.rd != 5'd0) && (s.rd == src) && u;
  endfunction

  // Returns which source an operand forwards from: 0 none, 1 ex, 2 mem,
  // 3 hz, 4 load. The youngest matching producer wins, except that a load
  // still in EX cannot supply data.
  function automatic int fwd_kind(input logic [4:0] src, input logic u);
    for (int k = 0; k < 3; k++) begin
      if (hit(pipe[k], src, u)) begin
        if (k == 0) begin
          if (!pipe[0].ld) return 1;
        end else if (k == 1) begin
          return pipe[1].ld ? 4 : 2;
        end else begin
          return 3;
        end
      end
    end
    return 0;
  endfunction

  function automatic logic [1:0] kind_bits(input int k1, input int k2, input int want);
    return {k1 == want, k2 == want};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_fex = '0; m_fmem = '0; m_fhz = '0; m_fload = '0;
    m_cnt = '0; m_state = 2'd0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic ld,
                       input logic redir, input logic busy);
    logic [6:0] ctrl;
    logic ldu;
    int k1, k2;
    @(negedge clk);
    rst = r; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
    id_use_rs2 = u2; id_wreg = rd; id_regwrite = wr; id_is_load = ld;
    redirect = redir; mem_busy = busy;
    ctrl = '0;
    if (!r) begin
      model_clear();
      exp_q.push_back({ctrl, m_fex, m_fmem, m_fhz, m_fload, m_cnt, m_state});
    end else begin
      ldu = v && pipe[0].v && pipe[0].ld &&
            (hit(pipe[0], rs1, u1) || hit(pipe[0], rs2, u2));
      // ctrl = {pc_keep, ifid_keep, idex_keep, idex_nop, ifid_flush, ex_keep, ex_nop}
      if (busy)       ctrl = 7'b1110010;
      else if (redir) ctrl = 7'b0001101;
      else if (ldu)   ctrl = 7'b1101000;
      exp_q.push_back({ctrl, m_fex, m_fmem, m_fhz, m_fload, m_cnt, m_state});
      // state after the coming edge
      if (ctrl[6] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (busy) begin
        m_state = 2'd2;
      end else begin
        if (!redir && !ldu && v) begin
          k1 = fwd_kind(rs1, u1);
          k2 = fwd_kind(rs2, u2);
        end else begin
          k1 = 0; k2 = 0;
        end
        m_fex   = kind_bits(k1, k2, 1);
        m_fmem  = kind_bits(k1, k2, 2);
        m_fhz   = kind_bits(k1, k2, 3);
        m_fload = kind_bits(k1, k2, 4);
        pipe[2] = pipe[1];
        pipe[1] = redir ? '0 : pipe[0];
        pipe[0] = (!redir && !ldu && v) ? ins_t'{1'b1, rd, wr, ld} : ins_t'('0);
        m_state = (!redir && ldu) ? 2'd1 : 2'd0;
      end
    end
  endtask

  task automatic bubble(input logic redir, input logic busy);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, redir, busy);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [OBS_W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {pc_keep, ifid_keep, idex_keep, idex_nop, ifid_flush, ex_keep, ex_nop,
                 fwd_ex_pyc, fwd_mem_pyc, fwd_hz_pyc, fwd_load_pyc, stall_cnt, state};
        chk("cycle_obs", 64'(act_v), 64'(exp_v));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // lw x5 ; add x6,x5,x1 -> one load stall, then load forward on rs1
    drive(1, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    drive(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
    drive(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
    bubble(0, 0); bubble(0, 0); bubble(0, 0);

    // add x3 ; sub x4,x3,x3 -> ex forward on both operands
    drive(1, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
    drive(1, 1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0, 0);
    bubble(0, 0); bubble(0, 0); bubble(0, 0);

    // x0 producer / consumer -> nothing
    drive(1, 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 1, 0, 0);
    drive(1, 1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, 0);
    bubble(0, 0); bubble(0, 0); bubble(0, 0);

    // redirect during a load-use hazard
    drive(1, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0);
    drive(1, 1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 1, 0);
    bubble(0, 0); bubble(0, 0);

    // mem_busy for 3 cycles with redirect held, flush on the 4th
    drive(1, 1, 5'd2, 1, 5'd0, 0, 5'd2, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 5'd2, 1, 5'd2, 1, 5'd9, 1, 0, 1, 1);
    drive(1, 1, 5'd2, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0);
    bubble(0, 0); bubble(0, 0);

    // reset in the middle of a memory wait
    drive(1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0);
    drive(1, 1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    drive(1, 1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    @(posedge clk);
    #2;
    chk("memwait_before_reset", 64'(state), 64'd2);
    rst = 1'b0;
    #1;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_fwd", 64'({fwd_ex_pyc, fwd_mem_pyc, fwd_hz_pyc, fwd_load_pyc}), 64'd0);
    chk("reset_ctrl", 64'({pc_keep, ifid_keep, idex_keep, idex_nop, ifid_flush,
                           ex_keep, ex_nop}), 64'd0);
    drive(1'b0, 1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0);

    // random traffic over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive(1'b1,
            1'($urandom_range(0, 9) < 8),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0));
    end

    bubble(0, 0);
    repeat (3) @(negedge clk);
    #5;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (0 = reset).
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source
- id_wreg  in  5  destination register of the ID instruction
- id_regwrite  in  1  the ID instruction writes its destination
- id_is_load  in  1  the ID instruction is a load
- redirect  in  1  branch_PC_contral OR csr_PC_contral, taken from the EX/MEM register
- mem_busy  in  1  data memory not ready
- pc_keep, ifid_keep, idex_keep  out  1 each  hold PC, IF/ID and ID/EX
- idex_nop  out  1  load a bubble into ID/EX
- ifid_flush  out  1  clear IF/ID
- ex_keep, ex_nop  out  1 each  drive execute keep and nop
- fwd_ex_pyc, fwd_mem_pyc, fwd_hz_pyc, fwd_load_pyc  out  2 each  forwarding selects; bit1 = rs1, bit0 = rs2
- stall_cnt  out  16  count of stall cycles
- state  out  2  current FSM state

Function
REQ-003 SHALL keep a shadow scoreboard with entries E (ID/EX), M (EX/MEM) and W (MEM/WB); each entry holds {valid, wreg, regwrite, is_load}.
REQ-004 The scoreboard SHALL shift ID->E->M->W on each advancing edge. E SHALL take an invalid entry on a bubble or flush. The scoreboard SHALL not shift while mem_busy is high.
REQ-005 A match SHALL require: entry valid, regwrite = 1, wreg != 0, wreg = the source register, and the matching use bit set.
REQ-006 Load-use hazard SHALL be: id_valid AND E.is_load AND a match on E.
REQ-007 FSM states SHALL be RUN = 0, LDSTALL = 1, MEMWAIT = 2. The encoding value 3 SHALL be unreachable and SHALL recover to RUN.
REQ-008 Action priority SHALL be mem_busy > redirect > load-use > advance.
REQ-009 mem_busy = 1 SHALL assert pc_keep, ifid_keep, idex_keep and ex_keep, and SHALL drive idex_nop = ex_nop = ifid_flush = 0.
- From any state the FSM SHALL go to MEMWAIT.
- The FSM SHALL leave MEMWAIT to RUN on the first cycle mem_busy = 0; hazards SHALL be re-evaluated in that cycle.
REQ-010 When redirect = 1 and mem_busy = 0, the block SHALL assert ifid_flush, idex_nop and ex_nop in that cycle, and SHALL invalidate E and the ID entry at the edge. The next state SHALL be RUN.
REQ-011 On load-use with no redirect and no mem_busy, the block SHALL assert pc_keep, ifid_keep and idex_nop for exactly one cycle; the next state SHALL be LDSTALL.
REQ-012 LDSTALL SHALL last one cycle and then return to RUN, or go to MEMWAIT if mem_busy = 1.
REQ-013 Forwarding selects SHALL be registered: computed from ID operands on an advancing edge and held while the ID instruction sits in EX.
- Each select SHALL be zero after a bubble or flush.
- Each select SHALL be held when idex_keep = 1.
REQ-014 Per operand bit, forwarding priority SHALL be:
- E match, non-load -> fwd_ex;
- else M match, load -> fwd_load;
- else M match, non-load -> fwd_mem;
- else W match -> fwd_hz.
At most one select bit per operand SHALL be set.
REQ-015 stall_cnt SHALL increment by one per cycle in which pc_keep = 1, and SHALL saturate at 16'hFFFF.
REQ-016 All keep, nop and flush outputs SHALL be combinational from the current state and inputs. All other outputs SHALL be registered.

Reset
REQ-017 rst = 0 SHALL immediately clear: the scoreboard (all invalid), state = RUN, every fwd_*_pyc = 0, stall_cnt = 0.
REQ-018 While rst = 0, all keep, nop and flush outputs SHALL be 0.
REQ-019 Reset asserted mid-MEMWAIT or mid-LDSTALL SHALL abandon the operation; no stall SHALL remain after release.

Verification
REQ-020 lw x5 in ID, then add x6,x5,x1 -> one cycle with pc_keep = ifid_keep = idex_nop = 1, state = 1; next cycle fwd_load_pyc = 2'b10; stall_cnt = 1.
REQ-021 add x3,..; sub x4,x3,x3 back-to-back -> no stall; fwd_ex_pyc = 2'b11 while sub is in EX.
REQ-022 Producer writes x0, consumer reads x0 -> all fwd selects = 0 and no stall.
REQ-023 redirect = 1 for one cycle during load-use -> ifid_flush = idex_nop = ex_nop = 1, no load stall, state = RUN.
REQ-024 mem_busy high for 3 cycles together with redirect -> all keeps = 1 for 3 cycles, state = 2, stall_cnt += 3; flush occurs on the 4th cycle.
REQ-025 rst pulsed low while in MEMWAIT -> state = 0, stall_cnt = 0, fwd selects = 0 immediately, without waiting for clk.
